// File: rtl/core_pkg.sv
// Shared definitions for the front end: reset vector, NOP encoding, fetch entry layout
// and fetch state encoding.
package core_pkg;

  localparam logic [31:0] CORE_RESET_PC = 32'h8000_0000;
  localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fault;
    logic        fault_cause;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// In-order fetch buffer: registered storage, combinational head read, synchronous flush.
// Push into a full buffer is legal only when a pop happens in the same cycle.
module fetch_fifo
  import core_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  fetch_entry_t                 push_data,
  input  logic                         pop,
  output fetch_entry_t                 head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  function automatic logic [AW-1:0] inc_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Storage is cleared on reset so the head reads as all-zero until the first push.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= inc_ptr(wr_ptr);
      end
      if (do_pop) rd_ptr <= inc_ptr(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush) assert (!(push && full && !pop));
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word reads, buffers responses in order and
// hands {instr, pc, fault} to decode. Redirects flush the buffer and drop in-flight reads.
module fetch_unit
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = CORE_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ibus_req,
  output logic [31:0] ibus_addr,
  input  logic        ibus_gnt,
  input  logic        ibus_rvalid,
  input  logic [31:0] ibus_rdata,
  input  logic        ibus_err,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        if_fault,
  output logic        if_fault_cause
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0] DEPTH_L = (CW + 1)'(FIFO_DEPTH);

  fetch_state_e  state_q, state_n;
  logic [31:0]   fetch_pc_q, fetch_pc_n, resp_pc_q, resp_pc_n;
  logic [CW-1:0] outst_q, outst_n, discard_q, discard_n, count, count_n;
  logic          mis_pend_q, mis_pend_n, req_q, req_n;
  logic          issue, resp_keep, mis_push, push, pop, full, empty;
  fetch_entry_t  push_data, head;

  // Handshakes: a bus read issues on any cycle with ibus_req && ibus_gnt, and ibus_req /
  // ibus_addr hold until then; decode takes an entry on any cycle with if_valid && if_ready,
  // and if_* hold until then. A redirect may withdraw either side.
  assign issue     = req_q && ibus_gnt;
  assign resp_keep = ibus_rvalid && (discard_q == '0);
  assign mis_push  = mis_pend_q && (discard_q == '0) && !full;
  assign push      = !redirect_valid && (resp_keep || mis_push);
  assign pop       = !empty && if_ready;

  always_comb begin
    if (mis_push)
      push_data = '{instr: NOP_INSTR, pc: fetch_pc_q, fault: 1'b1, fault_cause: 1'b1};
    else if (ibus_err)
      push_data = '{instr: NOP_INSTR, pc: resp_pc_q, fault: 1'b1, fault_cause: 1'b0};
    else
      push_data = '{instr: ibus_rdata, pc: resp_pc_q, fault: 1'b0, fault_cause: 1'b0};
  end

  // resp_pc tracks the PC of the next response that will be kept, independently of
  // fetch_pc which runs ahead by the number of kept reads still outstanding.
  always_comb begin
    state_n    = state_q;
    fetch_pc_n = fetch_pc_q;
    resp_pc_n  = resp_pc_q;
    mis_pend_n = mis_pend_q;
    discard_n  = discard_q;
    outst_n    = outst_q + CW'(issue) - CW'(ibus_rvalid);
    if (redirect_valid) begin
      discard_n  = outst_n;
      fetch_pc_n = redirect_pc;
      resp_pc_n  = redirect_pc;
      mis_pend_n = |redirect_pc[1:0];
      state_n    = RUN;
    end else begin
      if (ibus_rvalid && (discard_q != '0)) discard_n = discard_q - CW'(1);
      if (issue) fetch_pc_n = fetch_pc_q + 32'd4;
      if (resp_keep) begin
        resp_pc_n = resp_pc_q + 32'd4;
        if (ibus_err) state_n = HALT;
      end
      if (mis_push) begin
        mis_pend_n = 1'b0;
        state_n    = HALT;
      end
    end
    count_n = redirect_valid ? '0 : count + CW'(push) - CW'(pop);
    // Credit: buffered plus outstanding (discards included) never exceeds the buffer depth.
    req_n = (state_n == RUN) && !mis_pend_n &&
            (({1'b0, count_n} + {1'b0, outst_n}) < DEPTH_L);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      discard_q  <= '0;
      mis_pend_q <= 1'b0;
      req_q      <= 1'b0;
    end else begin
      state_q    <= state_n;
      fetch_pc_q <= fetch_pc_n;
      resp_pc_q  <= resp_pc_n;
      outst_q    <= outst_n;
      discard_q  <= discard_n;
      mis_pend_q <= mis_pend_n;
      req_q      <= req_n;
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .empty     (empty),
    .full      (full)
  );

  assign ibus_req       = req_q;
  assign ibus_addr      = fetch_pc_q;
  assign if_valid       = !empty;
  assign if_instr       = head.instr;
  assign if_pc          = head.pc;
  assign if_fault       = head.fault;
  assign if_fault_cause = head.fault_cause;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a bus responder model and an expected-entry queue.
module tb_fetch_unit;
  import core_pkg::*;

  logic        clk, rst;
  logic        ibus_req, ibus_gnt, ibus_rvalid, ibus_err;
  logic [31:0] ibus_addr, ibus_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid, if_ready, if_fault, if_fault_cause;
  logic [31:0] if_instr, if_pc;

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .ibus_req       (ibus_req),
    .ibus_addr      (ibus_addr),
    .ibus_gnt       (ibus_gnt),
    .ibus_rvalid    (ibus_rvalid),
    .ibus_rdata     (ibus_rdata),
    .ibus_err       (ibus_err),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_fault       (if_fault),
    .if_fault_cause (if_fault_cause)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  // ---------------- model state ----------------
  typedef struct {
    logic [31:0] addr;
    int          epoch;
  } pend_t;

  pend_t       pend_q[$];
  logic [65:0] exp_q[$];
  logic [31:0] pop_log[$];
  int          errors = 0;
  int          checks = 0;
  int          epoch = 0;
  int          gnt_pct, rsp_pct, rdy_pct;
  logic [31:0] exp_addr, err_addr;
  logic        halted, mis_mode, mis_wait, seen_err, seen_mis;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    ibus_gnt = 1'b0; ibus_rvalid = 1'b0; ibus_rdata = '0; ibus_err = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0; if_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ibus_req", {31'b0, ibus_req}, 32'd0);
    chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_if_instr", if_instr, 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_if_fault", {31'b0, if_fault}, 32'd0);
    chk("rst_if_fault_cause", {31'b0, if_fault_cause}, 32'd0);
    rst = 1'b0;
    pend_q.delete();
    exp_q.delete();
    epoch++;
    halted = 1'b0; mis_mode = 1'b0; mis_wait = 1'b0;
    exp_addr = 32'h8000_0000;
    err_addr = 32'hFFFF_FFFF;
  endtask

  // One clock: drive at negedge, check at negedge+1, update model after posedge.
  task automatic cycle(input logic redir, input logic [31:0] rpc);
    pend_t       p;
    logic [65:0] e;
    logic        s_req, s_gnt, s_rv, s_pop;
    logic [31:0] s_addr;
    @(negedge clk);
    ibus_gnt    = ($urandom_range(0, 99) < gnt_pct);
    ibus_rvalid = (pend_q.size() > 0) && ($urandom_range(0, 99) < rsp_pct);
    if (ibus_rvalid) begin
      ibus_rdata = data_of(pend_q[0].addr);
      ibus_err   = (pend_q[0].addr == err_addr);
    end else begin
      ibus_rdata = $urandom();
      ibus_err   = 1'($urandom_range(0, 1));
    end
    if_ready       = ($urandom_range(0, 99) < rdy_pct);
    redirect_valid = redir;
    redirect_pc    = rpc;
    #1;
    s_req = ibus_req; s_addr = ibus_addr; s_gnt = ibus_gnt; s_rv = ibus_rvalid;
    s_pop = if_valid && if_ready;
    if (!mis_wait) chk("if_valid", {31'b0, if_valid}, {31'b0, exp_q.size() != 0});
    if (s_req && !mis_mode)
      chk("credit", {31'b0, (pend_q.size() + exp_q.size()) < 2}, 32'd1);
    if (halted || mis_mode) chk("halt_no_req", {31'b0, s_req}, 32'd0);
    if (s_req && s_gnt) begin
      chk("ibus_addr", s_addr, exp_addr);
      exp_addr = exp_addr + 32'd4;
    end
    if (s_pop) begin
      chk("pop_has_entry", {31'b0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("if_instr", if_instr, e[65:34]);
        chk("if_pc", if_pc, e[33:2]);
        chk("if_fault", {31'b0, if_fault}, {31'b0, e[1]});
        chk("if_fault_cause", {31'b0, if_fault_cause}, {31'b0, e[0]});
        pop_log.push_back(if_pc);
        if (e[1] && e[0]) begin mis_wait = 1'b0; seen_mis = 1'b1; end
        if (e[1] && !e[0]) seen_err = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    if (s_rv) begin
      p = pend_q.pop_front();
      if (!redir && p.epoch == epoch) begin
        if (p.addr == err_addr) begin
          exp_q.push_back({NOP_INSTR, p.addr, 2'b10});
          halted = 1'b1;
        end else begin
          exp_q.push_back({data_of(p.addr), p.addr, 2'b00});
        end
      end
    end
    if (s_req && s_gnt) pend_q.push_back('{addr: s_addr, epoch: epoch});
    if (redir) begin
      exp_q.delete();
      epoch++;
      halted   = 1'b0;
      mis_mode = |rpc[1:0];
      mis_wait = mis_mode;
      exp_addr = rpc;
      if (mis_mode) exp_q.push_back({NOP_INSTR, rpc, 2'b11});
    end
  endtask

  task automatic set_rates(input int g, input int r, input int d);
    gnt_pct = g; rsp_pct = r; rdy_pct = d;
  endtask

  task automatic drain();
    int n;
    n = 0;
    set_rates(0, 100, 100);
    while ((pend_q.size() != 0 || exp_q.size() != 0) && n < 40) begin
      cycle(1'b0, 32'h0);
      n++;
    end
    chk("drain_done", {31'b0, n < 40}, 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int          n;
    logic [31:0] rpc;
    seen_err = 1'b0; seen_mis = 1'b0;
    set_rates(100, 100, 100);
    do_reset();

    // Sequential stream from the reset vector.
    pop_log.delete();
    repeat (12) cycle(1'b0, 32'h0);
    chk("t1_pops", {31'b0, pop_log.size() >= 3}, 32'd1);
    if (pop_log.size() >= 3) begin
      chk("t1_pc0", pop_log[0], 32'h8000_0000);
      chk("t1_pc1", pop_log[1], 32'h8000_0004);
      chk("t1_pc2", pop_log[2], 32'h8000_0008);
    end
    drain();

    // Decode stalls: requests stop once buffer plus outstanding reaches depth.
    set_rates(100, 100, 0);
    repeat (5) cycle(1'b0, 32'h0);
    chk("t2_req_drop", {31'b0, ibus_req}, 32'd0);
    chk("t2_full_valid", {31'b0, if_valid}, 32'd1);
    drain();

    // Redirect with two reads in flight.
    set_rates(100, 0, 100);
    n = 0;
    while (pend_q.size() < 2 && n < 10) begin cycle(1'b0, 32'h0); n++; end
    chk("t3_two_inflight", {31'b0, n < 10}, 32'd1);
    cycle(1'b1, 32'h8000_0100);
    pop_log.delete();
    set_rates(100, 100, 100);
    repeat (10) cycle(1'b0, 32'h0);
    chk("t3_pops", {31'b0, pop_log.size() >= 1}, 32'd1);
    if (pop_log.size() >= 1) chk("t3_first_pc", pop_log[0], 32'h8000_0100);
    drain();

    // Bus error on 8000_0008, then misaligned redirect.
    do_reset();
    err_addr = 32'h8000_0008;
    set_rates(100, 100, 100);
    repeat (15) cycle(1'b0, 32'h0);
    chk("t4_seen_fault", {31'b0, seen_err}, 32'd1);
    chk("t4_halt_req", {31'b0, ibus_req}, 32'd0);
    cycle(1'b1, 32'h8000_0102);
    repeat (10) cycle(1'b0, 32'h0);
    chk("t5_seen_mis", {31'b0, seen_mis}, 32'd1);
    chk("t5_halt_req", {31'b0, ibus_req}, 32'd0);
    drain();

    // Redirect coinciding with a grant and a response; new stream wraps through zero.
    set_rates(100, 100, 100);
    cycle(1'b1, 32'h8000_0200);
    n = 0;
    while (!(ibus_req && pend_q.size() > 0) && n < 20) begin cycle(1'b0, 32'h0); n++; end
    chk("t6_align", {31'b0, n < 20}, 32'd1);
    cycle(1'b1, 32'hFFFF_FFFC);
    pop_log.delete();
    repeat (12) cycle(1'b0, 32'h0);
    chk("t6_pops", {31'b0, pop_log.size() >= 3}, 32'd1);
    if (pop_log.size() >= 3) begin
      chk("t6_pc0", pop_log[0], 32'hFFFF_FFFC);
      chk("t6_pc1", pop_log[1], 32'h0000_0000);
      chk("t6_pc2", pop_log[2], 32'h0000_0004);
    end
    drain();

    // Randomised traffic with occasional redirects, some misaligned, and an error address.
    err_addr = 32'h8000_1040;
    set_rates(100, 100, 100);
    cycle(1'b1, 32'h8000_1000);
    set_rates(70, 60, 60);
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 99) < 3) begin
        rpc = 32'h8000_1000 + (32'($urandom_range(0, 31)) << 2);
        if ($urandom_range(0, 9) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
        cycle(1'b1, rpc);
      end else begin
        cycle(1'b0, 32'h0);
      end
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
